out_periph_ctrl: RTL and testbench

Parametrised memory-mapped output peripheral for the single-cycle RISC-V core. It drives the red/green LEDs, NUM_HEX seven-segment digits and the 12-bit LCD bus.
- Stores are byte-lane accurate, and loads read back register contents with RV32 sign/zero extension.
- New over the previous generation: a per-digit hex blink engine, and an LCD write sequencer that generates the EN strobe timing and reports busy status.

---
 rtl/out_periph_pkg.sv | 58 +++++
 rtl/out_periph_ctrl_lcd_seq.sv | 110 +++++++++++
 rtl/out_periph_ctrl.sv | 161 ++++++++++++++++
 tb/tb_out_periph_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/out_periph_pkg.sv
// Shared definitions for the output peripheral: address map, RV32 size codes,
// LCD sequencer states and byte-lane helpers.
package out_periph_pkg;

   localparam logic [7:0] OFF_LEDR     = 8'h00;
   localparam logic [7:0] OFF_LEDG     = 8'h10;
   localparam logic [7:0] OFF_HEX      = 8'h20;
   localparam logic [7:0] OFF_LCD_CTRL = 8'h30;
   localparam logic [7:0] OFF_LCD_STAT = 8'h34;
   localparam logic [7:0] OFF_BLINK    = 8'h38;

   typedef enum logic [2:0] {
      F3_SB  = 3'd0,
      F3_SH  = 3'd1,
      F3_SW  = 3'd2,
      F3_LBU = 3'd4,
      F3_LHU = 3'd5
   } funct3_e;

   // Loads share their size codes with the matching stores.
   localparam logic [2:0] F3_LB = 3'd0;
   localparam logic [2:0] F3_LH = 3'd1;
   localparam logic [2:0] F3_LW = 3'd2;

   typedef enum logic [1:0] {
      LCD_IDLE  = 2'd0,
      LCD_SETUP = 2'd1,
      LCD_PULSE = 2'd2,
      LCD_HOLD  = 2'd3
   } lcd_state_e;

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      return ((f3 == F3_SH) && a[0]) || ((f3 == F3_SW) && (a != 2'd0));
   endfunction

   // Bytes touched by a store; misaligned or non-store codes touch nothing.
   function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
      logic [3:0] m;
      case (f3)
         F3_SB:   m = 4'b0001 << a;
         F3_SH:   m = a[0] ? 4'b0000 : (4'b0011 << a);
         F3_SW:   m = (a == 2'd0) ? 4'b1111 : 4'b0000;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  lanes);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = lanes[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/out_periph_ctrl_lcd_seq.sv
// LCD write sequencer: latches a command, then walks SETUP/PULSE/HOLD to
// generate the EN strobe, and flags commands that arrive while busy.
module lcd_seq
   import out_periph_pkg::*;
#(
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 4,
   parameter int HOLD_CYC  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        byte1_we,
   input  logic [7:0]  data,
   input  logic        rs,
   input  logic        on,
   input  logic        clr_dropped,
   output logic [11:0] lcd,
   output logic        busy,
   output logic        dropped
);

   lcd_state_e  state_r, state_s;
   logic [31:0] cnt_r, cnt_s;
   logic [7:0]  data_r;
   logic        rs_r, on_r, en_r, busy_r, dropped_r;
   logic        accept_s;

   assign accept_s = req && (state_r == LCD_IDLE);

   // Next-state and down-counter; each phase loads its length minus one.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         LCD_IDLE: begin
            if (req) begin
               state_s = LCD_SETUP;
               cnt_s   = 32'(SETUP_CYC - 1);
            end else begin
               cnt_s   = 32'd0;
            end
         end
         LCD_SETUP: begin
            if (cnt_r == 32'd0) begin
               state_s = LCD_PULSE;
               cnt_s   = 32'(PULSE_CYC - 1);
            end else begin
               cnt_s   = cnt_r - 32'd1;
            end
         end
         LCD_PULSE: begin
            if (cnt_r == 32'd0) begin
               state_s = LCD_HOLD;
               cnt_s   = 32'(HOLD_CYC - 1);
            end else begin
               cnt_s   = cnt_r - 32'd1;
            end
         end
         LCD_HOLD: begin
            if (cnt_r == 32'd0) begin
               state_s = LCD_IDLE;
               cnt_s   = 32'd0;
            end else begin
               cnt_s   = cnt_r - 32'd1;
            end
         end
         default: begin
            state_s = LCD_IDLE;
            cnt_s   = 32'd0;
         end
      endcase
   end

   // State, strobe and command registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= LCD_IDLE;
         cnt_r     <= 32'd0;
         data_r    <= 8'h00;
         rs_r      <= 1'b0;
         on_r      <= 1'b0;
         en_r      <= 1'b0;
         busy_r    <= 1'b0;
         dropped_r <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         en_r    <= (state_s == LCD_PULSE);
         busy_r  <= (state_s != LCD_IDLE);
         if (accept_s) begin
            data_r <= data;
            if (byte1_we) begin
               rs_r <= rs;
               on_r <= on;
            end
         end
         if (clr_dropped) begin
            dropped_r <= 1'b0;
         end else if (req && (state_r != LCD_IDLE)) begin
            dropped_r <= 1'b1;
         end
      end
   end

   assign lcd     = {on_r, en_r, rs_r, 1'b0, data_r};
   assign busy    = busy_r;
   assign dropped = dropped_r;

endmodule

// File: rtl/out_periph_ctrl.sv
// Memory-mapped output peripheral: LEDs, blinking seven-segment digits and
// a sequenced LCD port, with byte-lane stores and sign/zero-extending loads.
module out_periph_ctrl
   import out_periph_pkg::*;
#(
   parameter int NUM_HEX   = 8,
   parameter int LEDR_W    = 17,
   parameter int LEDG_W    = 8,
   parameter int LCD_SETUP = 2,
   parameter int LCD_PULSE = 4,
   parameter int LCD_HOLD  = 2,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   st_en_i,
   input  logic [2:0]             funct3_i,
   input  logic [7:0]             addr_i,
   input  logic [31:0]            st_data_i,
   output logic [31:0]            ld_data_o,
   output logic [7*NUM_HEX-1:0]   o_io_hex,
   output logic [LEDR_W-1:0]      o_io_ledr,
   output logic [LEDG_W-1:0]      o_io_ledg,
   output logic [11:0]            o_io_lcd,
   output logic                   lcd_busy_o,
   output logic                   misalign_o
);

   localparam int BW = $clog2(BLINK_DIV);

   logic [LEDR_W-1:0]  ledr_r;
   logic [LEDG_W-1:0]  ledg_r;
   logic [6:0]         hex_r [NUM_HEX];
   logic [NUM_HEX-1:0] blink_mask_r;
   logic [BW-1:0]      blink_cnt_r;
   logic               blink_phase_r;
   logic               misalign_r;

   logic [3:0]         mask_s;
   logic [31:0]        wdata_s;
   logic               sel_ledr_s, sel_ledg_s, sel_hex_s, sel_ctrl_s, sel_stat_s, sel_blink_s;
   logic [15:0]        hex_we_s;
   logic [15:0][7:0]   hex_all_s;
   logic [31:0]        rd_word_s;
   logic [15:0]        rd_half_s;
   logic               lcd_dropped_s;

   assign mask_s  = st_en_i ? lane_mask(funct3_i, addr_i[1:0]) : 4'b0000;
   assign wdata_s = st_data_i << {addr_i[1:0], 3'b000};

   assign sel_ledr_s  = (addr_i[7:2] == OFF_LEDR[7:2]);
   assign sel_ledg_s  = (addr_i[7:2] == OFF_LEDG[7:2]);
   assign sel_hex_s   = (addr_i[7:4] == OFF_HEX[7:4]);
   assign sel_ctrl_s  = (addr_i[7:2] == OFF_LCD_CTRL[7:2]);
   assign sel_stat_s  = (addr_i[7:2] == OFF_LCD_STAT[7:2]);
   assign sel_blink_s = (addr_i[7:2] == OFF_BLINK[7:2]);

   // Digit slot n lives in byte n%4 of hex word n/4.
   assign hex_we_s = sel_hex_s ? (16'(mask_s) << {addr_i[3:2], 2'b00}) : 16'h0000;

   // LED, digit, blink-mask and misalign registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ledr_r       <= '0;
         ledg_r       <= '0;
         blink_mask_r <= '0;
         misalign_r   <= 1'b0;
         for (int d = 0; d < NUM_HEX; d++) begin
            hex_r[d] <= 7'h7F;
         end
      end else begin
         misalign_r <= st_en_i && is_misaligned(funct3_i, addr_i[1:0]);
         if (sel_ledr_s) begin
            ledr_r <= LEDR_W'(merge_word(32'(ledr_r), wdata_s, mask_s));
         end
         if (sel_ledg_s) begin
            ledg_r <= LEDG_W'(merge_word(32'(ledg_r), wdata_s, mask_s));
         end
         if (sel_blink_s) begin
            blink_mask_r <= NUM_HEX'(merge_word(32'(blink_mask_r), wdata_s, mask_s));
         end
         for (int d = 0; d < NUM_HEX; d++) begin
            if (hex_we_s[d]) begin
               hex_r[d] <= wdata_s[8*(d%4) +: 7];
            end
         end
      end
   end

   // Free-running blink divider; phase flips each time the count wraps.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         blink_cnt_r   <= '0;
         blink_phase_r <= 1'b0;
      end else if (blink_cnt_r == BW'(BLINK_DIV - 1)) begin
         blink_cnt_r   <= '0;
         blink_phase_r <= ~blink_phase_r;
      end else begin
         blink_cnt_r   <= blink_cnt_r + BW'(1);
      end
   end

   for (genvar d = 0; d < NUM_HEX; d++) begin : g_hex_out
      assign o_io_hex[7*d +: 7] = (blink_mask_r[d] && blink_phase_r) ? 7'h7F : hex_r[d];
   end

   lcd_seq #(
      .SETUP_CYC (LCD_SETUP),
      .PULSE_CYC (LCD_PULSE),
      .HOLD_CYC  (LCD_HOLD)
   ) u_lcd_seq (
      .clk         (clk_i),
      .rst         (rst_i),
      .req         (sel_ctrl_s && mask_s[0]),
      .byte1_we    (mask_s[1]),
      .data        (wdata_s[7:0]),
      .rs          (wdata_s[9]),
      .on          (wdata_s[11]),
      .clr_dropped (sel_stat_s && (mask_s != 4'b0000)),
      .lcd         (o_io_lcd),
      .busy        (lcd_busy_o),
      .dropped     (lcd_dropped_s)
   );

   // Read mux and RV32 load extension; reads see stored values, never blanking.
   always_comb begin
      hex_all_s = '0;
      for (int d = 0; d < NUM_HEX; d++) begin
         hex_all_s[d] = {1'b0, hex_r[d]};
      end
      if (sel_ledr_s) begin
         rd_word_s = 32'(ledr_r);
      end else if (sel_ledg_s) begin
         rd_word_s = 32'(ledg_r);
      end else if (sel_hex_s) begin
         rd_word_s = hex_all_s[{addr_i[3:2], 2'b00} +: 4];
      end else if (sel_ctrl_s) begin
         rd_word_s = {20'h00000, o_io_lcd[11], 1'b0, o_io_lcd[9], 1'b0, o_io_lcd[7:0]};
      end else if (sel_stat_s) begin
         rd_word_s = {30'h00000000, lcd_dropped_s, lcd_busy_o};
      end else if (sel_blink_s) begin
         rd_word_s = 32'(blink_mask_r);
      end else begin
         rd_word_s = 32'h0000_0000;
      end
      rd_half_s = 16'(rd_word_s >> {addr_i[1:0], 3'b000});
      case (funct3_i)
         F3_LB:   ld_data_o = {{24{rd_half_s[7]}}, rd_half_s[7:0]};
         F3_LH:   ld_data_o = {{16{rd_half_s[15]}}, rd_half_s};
         F3_LW:   ld_data_o = rd_word_s;
         F3_LBU:  ld_data_o = {24'h000000, rd_half_s[7:0]};
         F3_LHU:  ld_data_o = {16'h0000, rd_half_s};
         default: ld_data_o = 32'h0000_0000;
      endcase
   end

   assign o_io_ledr  = ledr_r;
   assign o_io_ledg  = ledg_r;
   assign misalign_o = misalign_r;

endmodule

// File: tb/tb_out_periph_ctrl.sv
// Directed bench for out_periph_ctrl: a table of stores/loads, then hand
// sequences for misalign, LCD timing, reset abort and blinking.
module tb_out_periph_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_en;
   logic [2:0]  funct3;
   logic [7:0]  addr;
   logic [31:0] st_data;
   logic [31:0] ld_data;
   logic [55:0] hex;
   logic [16:0] ledr;
   logic [7:0]  ledg;
   logic [11:0] lcd;
   logic        busy;
   logic        mis;

   int total = 0;
   int bad   = 0;

   int   bcnt;
   logic bph;

   out_periph_ctrl #(
      .NUM_HEX(8), .LEDR_W(17), .LEDG_W(8),
      .LCD_SETUP(2), .LCD_PULSE(4), .LCD_HOLD(2), .BLINK_DIV(4)
   ) dut (
      .clk_i(clk), .rst_i(rst), .st_en_i(st_en), .funct3_i(funct3), .addr_i(addr),
      .st_data_i(st_data), .ld_data_o(ld_data), .o_io_hex(hex), .o_io_ledr(ledr),
      .o_io_ledg(ledg), .o_io_lcd(lcd), .lcd_busy_o(busy), .misalign_o(mis)
   );

   always #5 clk = ~clk;

   // Reference blink timing: 4-cycle half periods starting visible after reset.
   always @(posedge clk) begin
      if (rst) begin
         bcnt <= 0;
         bph  <= 1'b0;
      end else if (bcnt == 3) begin
         bcnt <= 0;
         bph  <= ~bph;
      end else begin
         bcnt <= bcnt + 1;
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic store(input logic [2:0] f, input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      st_en = 1'b1; funct3 = f; addr = a; st_data = d;
      @(negedge clk);
      st_en = 1'b0;
   endtask

   typedef struct packed {
      logic        st;
      logic [2:0]  f3;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 32;
   vec_t vecs [NV];

   initial begin
      logic [27:0] exp_lo;
      logic [55:0] exp_hex;

      vecs[0]  = '{1'b1, 3'd2, 8'h00, 32'h0001ABCD, 32'h0};
      vecs[1]  = '{1'b0, 3'd2, 8'h00, 32'h0, 32'h0001ABCD};
      vecs[2]  = '{1'b0, 3'd0, 8'h00, 32'h0, 32'hFFFFFFCD};
      vecs[3]  = '{1'b0, 3'd4, 8'h00, 32'h0, 32'h000000CD};
      vecs[4]  = '{1'b0, 3'd1, 8'h02, 32'h0, 32'h00000001};
      vecs[5]  = '{1'b0, 3'd5, 8'h00, 32'h0, 32'h0000ABCD};
      vecs[6]  = '{1'b0, 3'd1, 8'h00, 32'h0, 32'hFFFFABCD};
      vecs[7]  = '{1'b1, 3'd0, 8'h23, 32'h00000040, 32'h0};
      vecs[8]  = '{1'b0, 3'd4, 8'h23, 32'h0, 32'h00000040};
      vecs[9]  = '{1'b0, 3'd2, 8'h20, 32'h0, 32'h407F7F7F};
      vecs[10] = '{1'b1, 3'd0, 8'h24, 32'h00000085, 32'h0};
      vecs[11] = '{1'b0, 3'd0, 8'h24, 32'h0, 32'h00000005};
      vecs[12] = '{1'b1, 3'd1, 8'h10, 32'h12345678, 32'h0};
      vecs[13] = '{1'b0, 3'd2, 8'h10, 32'h0, 32'h00000078};
      vecs[14] = '{1'b1, 3'd0, 8'h11, 32'h000000AA, 32'h0};
      vecs[15] = '{1'b0, 3'd2, 8'h10, 32'h0, 32'h00000078};
      vecs[16] = '{1'b1, 3'd2, 8'h04, 32'hFFFFFFFF, 32'h0};
      vecs[17] = '{1'b0, 3'd2, 8'h04, 32'h0, 32'h00000000};
      vecs[18] = '{1'b1, 3'd3, 8'h00, 32'h00000000, 32'h0};
      vecs[19] = '{1'b0, 3'd2, 8'h00, 32'h0, 32'h0001ABCD};
      vecs[20] = '{1'b0, 3'd6, 8'h00, 32'h0, 32'h00000000};
      vecs[21] = '{1'b1, 3'd1, 8'h02, 32'h00000000, 32'h0};
      vecs[22] = '{1'b0, 3'd2, 8'h00, 32'h0, 32'h0000ABCD};
      vecs[23] = '{1'b1, 3'd2, 8'h28, 32'hFFFFFFFF, 32'h0};
      vecs[24] = '{1'b0, 3'd2, 8'h28, 32'h0, 32'h00000000};
      vecs[25] = '{1'b1, 3'd2, 8'h24, 32'h04030201, 32'h0};
      vecs[26] = '{1'b0, 3'd2, 8'h24, 32'h0, 32'h04030201};
      vecs[27] = '{1'b0, 3'd1, 8'h22, 32'h0, 32'h0000407F};
      vecs[28] = '{1'b0, 3'd2, 8'h3C, 32'h0, 32'h00000000};
      vecs[29] = '{1'b0, 3'd2, 8'h30, 32'h0, 32'h00000000};
      vecs[30] = '{1'b1, 3'd0, 8'h01, 32'h000000EF, 32'h0};
      vecs[31] = '{1'b0, 3'd2, 8'h00, 32'h0, 32'h0000EFCD};

      rst = 1'b1; st_en = 1'b0; funct3 = 3'd2; addr = 8'h20; st_data = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_hex", hex, {8{7'h7F}});
      check("rst_ledr", ledr, 0);
      check("rst_ledg", ledg, 0);
      check("rst_lcd", lcd, 0);
      check("rst_busy", busy, 0);
      check("rst_mis", mis, 0);
      check("rst_ld_hex", ld_data, 32'h7F7F7F7F);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         st_en = vecs[i].st; funct3 = vecs[i].f3; addr = vecs[i].addr; st_data = vecs[i].data;
         if (!vecs[i].st) begin
            #1;
            check($sformatf("vec%0d", i), ld_data, vecs[i].exp);
         end
      end
      @(negedge clk);
      st_en = 1'b0;
      #1;
      check("ledr_out", ledr, 17'h0EFCD);
      check("ledg_out", ledg, 8'h78);
      exp_hex = {7'h04, 7'h03, 7'h02, 7'h01, 7'h40, 7'h7F, 7'h7F, 7'h7F};
      check("hex_out", hex, exp_hex);

      // Misaligned halfword into the digit space.
      @(negedge clk);
      st_en = 1'b1; funct3 = 3'd1; addr = 8'h21; st_data = 32'h00001111;
      #1;
      check("mis_pre", mis, 0);
      @(negedge clk);
      st_en = 1'b0; funct3 = 3'd2; addr = 8'h20;
      #1;
      check("mis_pulse", mis, 1);
      check("mis_nowrite", ld_data, 32'h407F7F7F);
      @(negedge clk);
      #1;
      check("mis_end", mis, 0);

      // LCD write with a mid-sequence store and one on the HOLD-expiry edge.
      @(negedge clk);
      st_en = 1'b1; funct3 = 3'd2; addr = 8'h30; st_data = 32'h00000A41;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         st_en = 1'b0; funct3 = 3'd2; addr = 8'h34;
         #1;
         check($sformatf("lcd_c%0d", k), lcd, {1'b1, (k >= 3 && k <= 6), 1'b1, 1'b0, 8'h41});
         check($sformatf("busy_c%0d", k), busy, (k >= 1 && k <= 8));
         if (k == 4) begin
            check("stat_busy", ld_data, 32'h3);
         end
         if (k == 2 || k == 8) begin
            st_en = 1'b1; addr = 8'h30; st_data = (k == 2) ? 32'h00000B55 : 32'h00000022;
         end
      end
      @(negedge clk);
      #1;
      check("stat_idle", ld_data, 32'h2);
      check("lcd_kept", lcd, 12'hA41);
      store(3'd2, 8'h34, 32'h00000000);
      funct3 = 3'd2; addr = 8'h34;
      #1;
      check("stat_clr", ld_data, 32'h0);

      // Reset in the middle of the EN pulse.
      store(3'd2, 8'h30, 32'h00000A33);
      repeat (3) @(negedge clk);
      #1;
      check("pulse_en", lcd[10], 1'b1);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("abort_lcd", lcd, 0);
      check("abort_busy", busy, 0);
      rst = 1'b0; st_en = 1'b1; funct3 = 3'd2; addr = 8'h30; st_data = 32'h00000255;
      @(negedge clk);
      st_en = 1'b0;
      #1;
      check("post_rst_busy", busy, 1);
      check("post_rst_lcd", lcd, 12'h255);
      repeat (9) @(negedge clk);
      #1;
      check("post_rst_idle", busy, 0);

      // Blink digits 0 and 2 against the reference phase.
      store(3'd2, 8'h20, 32'h03020100);
      store(3'd2, 8'h38, 32'h00000005);
      funct3 = 3'd2; addr = 8'h20;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         #1;
         exp_lo = {7'h03, bph ? 7'h7F : 7'h02, 7'h01, bph ? 7'h7F : 7'h00};
         check($sformatf("blink_c%0d", c), hex[27:0], exp_lo);
         check($sformatf("blink_ld%0d", c), ld_data, 32'h03020100);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
